// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and fetch/execute sequencer for the single-cycle core.
// Ports: clk, rst (async active-low); imem request/response handshake;
//   inst/inst_valid to decode, exec_done/redirect/branch_target/halt_req
//   back from execute; pc, retired_cnt, halted, err status.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic        redirect,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic [31:0] retired_cnt,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EXEC,
        HALT
    } state_t;

    // Last counter value before the wait limit fires; unused when disabled.
    localparam logic [15:0] TMO_LAST =
        (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam bit TMO_EN = (TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] inst_q, inst_d;
    logic        ivld_q, ivld_d;
    logic [31:0] ret_q, ret_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;
    logic [15:0] tmo_q, tmo_d;

    logic [31:0] pc_next;
    logic        tgt_misal;

    assign tgt_misal = (branch_target[1:0] != 2'b00);
    assign pc_next   = redirect ? branch_target : (pc_q + 32'd4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= 32'd0;
            req_q    <= 1'b0;
            inst_q   <= 32'd0;
            ivld_q   <= 1'b0;
            ret_q    <= 32'd0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            inst_q   <= inst_d;
            ivld_q   <= ivld_d;
            ret_q    <= ret_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        req_d    = req_q;
        inst_d   = inst_q;
        ivld_d   = ivld_q;
        ret_d    = ret_q;
        halted_d = halted_q;
        err_d    = err_q;
        tmo_d    = tmo_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end

            REQ: begin
                // Request stays up until accepted; address held in addr_q.
                if (req_q && imem_req_ready) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                    tmo_d   = 16'd0;
                end
            end

            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = EXEC;
                    inst_d  = imem_rsp_data;
                    ivld_d  = 1'b1;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    state_d  = HALT;
                    err_d    = 1'b1;
                    halted_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            EXEC: begin
                if (exec_done) begin
                    ret_d  = ret_q + 32'd1;
                    ivld_d = 1'b0;
                    if (halt_req) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else if (redirect && tgt_misal) begin
                        state_d  = HALT;
                        err_d    = 1'b1;
                        halted_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        pc_d    = pc_next;
                        addr_d  = pc_next;
                        req_d   = 1'b1;
                    end
                end
            end

            HALT: begin
                req_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign imem_req_valid = req_q;
    assign imem_addr      = addr_q;
    assign inst           = inst_q;
    assign inst_valid     = ivld_q;
    assign pc             = pc_q;
    assign retired_cnt    = ret_q;
    assign halted         = halted_q;
    assign err            = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl.
// Instruction table plus hand sequences for stall, halt, timeout, reset.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exec_done;
    logic        redirect;
    logic [31:0] branch_target;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] retired_cnt;
    logic        halted;
    logic        err;

    fetch_ctrl #(
        .RESET_PC(32'h8000_0000),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .exec_done     (exec_done),
        .redirect      (redirect),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .pc            (pc),
        .retired_cnt   (retired_cnt),
        .halted        (halted),
        .err           (err)
    );

    typedef struct {
        logic [31:0] data;
        logic        redir;
        logic [31:0] tgt;
        logic        hreq;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_ret;
        logic        exp_halt;
        logic        exp_err;
    } vec_t;

    int errs;
    int checks;
    int cyc;
    int last_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        exec_done      = 1'b0;
        redirect       = 1'b0;
        branch_target  = 32'd0;
        halt_req       = 1'b0;
        tick();
        tick();
        rst      = 1'b1;
        last_req = -1;
    endtask

    task automatic do_inst(input vec_t v, input int idx, input bit lat);
        bit ok;
        wait_req(ok);
        chk($sformatf("v%0d req_seen", idx), 32'(ok), 32'd1);
        if (!ok) return;
        if (lat && last_req >= 0)
            chk($sformatf("v%0d latency", idx), 32'(cyc - last_req), 32'd4);
        last_req = cyc;
        chk($sformatf("v%0d addr", idx), imem_addr, v.exp_addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = v.data;
        tick();
        imem_rsp_valid = 1'b0;
        chk($sformatf("v%0d inst_valid", idx), 32'(inst_valid), 32'd1);
        chk($sformatf("v%0d inst", idx), inst, v.data);
        tick();
        exec_done     = 1'b1;
        redirect      = v.redir;
        branch_target = v.tgt;
        halt_req      = v.hreq;
        tick();
        exec_done = 1'b0;
        redirect  = 1'b0;
        halt_req  = 1'b0;
        chk($sformatf("v%0d pc", idx), pc, v.exp_pc);
        chk($sformatf("v%0d retired", idx), retired_cnt, v.exp_ret);
        chk($sformatf("v%0d halted", idx), 32'(halted), 32'(v.exp_halt));
        chk($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
    endtask

    vec_t tbl[6];
    vec_t one;

    initial begin
        bit ok;
        errs     = 0;
        checks   = 0;
        last_req = -1;

        tbl[0] = '{32'h0000_0013, 1'b0, 32'h0, 1'b0,
                   32'h8000_0000, 32'h8000_0004, 32'd1, 1'b0, 1'b0};
        tbl[1] = '{32'h0010_0093, 1'b0, 32'h0, 1'b0,
                   32'h8000_0004, 32'h8000_0008, 32'd2, 1'b0, 1'b0};
        tbl[2] = '{32'h0F80_006F, 1'b1, 32'h8000_0100, 1'b0,
                   32'h8000_0008, 32'h8000_0100, 32'd3, 1'b0, 1'b0};
        tbl[3] = '{32'hABCD_1234, 1'b1, 32'hFFFF_FFFC, 1'b0,
                   32'h8000_0100, 32'hFFFF_FFFC, 32'd4, 1'b0, 1'b0};
        tbl[4] = '{32'h5555_AAAA, 1'b0, 32'h0, 1'b0,
                   32'hFFFF_FFFC, 32'h0000_0000, 32'd5, 1'b0, 1'b0};
        tbl[5] = '{32'h1234_5678, 1'b1, 32'h8000_0102, 1'b0,
                   32'h0000_0000, 32'h0000_0000, 32'd6, 1'b1, 1'b1};

        // Reset state
        do_reset();
        rst = 1'b0;
        #1;
        chk("rst pc", pc, 32'h8000_0000);
        chk("rst req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst addr", imem_addr, 32'd0);
        chk("rst inst", inst, 32'd0);
        chk("rst inst_valid", 32'(inst_valid), 32'd0);
        chk("rst retired", retired_cnt, 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        tick();
        rst      = 1'b1;
        last_req = -1;

        // Table: sequential, redirect, wrap, misaligned target
        for (int i = 0; i < 6; i++) do_inst(tbl[i], i, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("misal no_req", 32'(imem_req_valid), 32'd0);
        end
        chk("misal err_hold", 32'(err), 32'd1);

        // Request stall, then halt with redirect together
        do_reset();
        wait_req(ok);
        chk("stall req_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall valid", 32'(imem_req_valid), 32'd1);
            chk("stall addr", imem_addr, 32'h8000_0000);
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("stall accepted", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0073;
        tick();
        imem_rsp_valid = 1'b0;
        chk("ebreak inst_valid", 32'(inst_valid), 32'd1);
        exec_done     = 1'b1;
        halt_req      = 1'b1;
        redirect      = 1'b1;
        branch_target = 32'h8000_0200;
        tick();
        exec_done = 1'b0;
        halt_req  = 1'b0;
        redirect  = 1'b0;
        chk("ebreak halted", 32'(halted), 32'd1);
        chk("ebreak err", 32'(err), 32'd0);
        chk("ebreak pc", pc, 32'h8000_0000);
        chk("ebreak retired", retired_cnt, 32'd1);
        chk("ebreak inst_valid0", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ebreak no_req", 32'(imem_req_valid), 32'd0);
        end

        // Response timeout
        do_reset();
        wait_req(ok);
        chk("tmo req_seen", 32'(ok), 32'd1);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("tmo err_early", 32'(err), 32'd0);
        tick();
        chk("tmo err", 32'(err), 32'd1);
        chk("tmo halted", 32'(halted), 32'd1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        tick();
        chk("tmo late_rsp", 32'(inst_valid), 32'd0);
        chk("tmo no_req", 32'(imem_req_valid), 32'd0);

        // Asynchronous reset during WAIT
        do_reset();
        one = '{32'h0000_0013, 1'b0, 32'h0, 1'b0,
                32'h8000_0000, 32'h8000_0004, 32'd1, 1'b0, 1'b0};
        do_inst(one, 10, 1'b0);
        wait_req(ok);
        chk("arst req_seen", 32'(ok), 32'd1);
        chk("arst addr2", imem_addr, 32'h8000_0004);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        #2;
        rst = 1'b0;
        #1;
        chk("arst pc", pc, 32'h8000_0000);
        chk("arst retired", retired_cnt, 32'd0);
        chk("arst addr", imem_addr, 32'd0);
        chk("arst inst_valid", 32'(inst_valid), 32'd0);
        tick();
        tick();
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        last_req       = -1;
        wait_req(ok);
        chk("arst restart", 32'(ok), 32'd1);
        chk("arst restart_addr", imem_addr, 32'h8000_0000);
        chk("arst restart_ret", retired_cnt, 32'd0);
        chk("arst restart_iv", 32'(inst_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Multi-cycle sequencer that drives the single-cycle core's fetch/execute loop.
- Owns the PC and issues instruction-memory requests over a valid/ready handshake.
- Presents the fetched instruction to the decode/execute stage and waits for its completion pulse.
- Updates the PC (sequential or redirect), counts retired instructions, and halts on ebreak, misaligned target, or memory timeout.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles spent in WAIT before error; 0 disables the timeout

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  fetch address (= pc while imem_req_valid)
imem_rsp_valid  in  1  response data valid
imem_rsp_data  in  32  fetched instruction word
inst  out  32  latched instruction for decode/exec
inst_valid  out  1  inst is valid, held until exec_done
exec_done  in  1  one-cycle pulse: current instruction complete
redirect  in  1  sampled with exec_done: take branch_target
branch_target  in  32  next PC when redirect=1
halt_req  in  1  sampled with exec_done: instruction is ebreak
pc  out  32  current PC
retired_cnt  out  32  retired instruction count
halted  out  1  core stopped
err  out  1  stopped due to error (misaligned target or timeout)

Behaviour:
- Reset (rst=0, asynchronous): all outputs and state forced to the following values, regardless of current state:
  - state=IDLE, pc=RESET_PC
  - inst=0, inst_valid=0, imem_req_valid=0, imem_addr=0
  - retired_cnt=0, halted=0, err=0, timeout counter=0
- Reset mid-transaction: any outstanding memory response is dropped.
- States: IDLE, REQ, WAIT, EXEC, HALT.
- IDLE: unconditional -> REQ on the next clock after reset deasserts.
- REQ:
  - imem_req_valid=1, imem_addr=pc (registered, stable while waiting).
  - On valid&&ready -> WAIT; imem_req_valid drops next cycle.
  - valid must not drop before ready.
- WAIT:
  - imem_req_valid=0; timeout counter increments each cycle.
  - On imem_rsp_valid: inst<=imem_rsp_data, inst_valid<=1, -> EXEC.
  - imem_rsp_valid in any state other than WAIT is ignored.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with no response: err<=1, halted<=1, -> HALT. The counter clears on entering WAIT.
- EXEC:
  - inst and inst_valid held constant; exec_done is ignored while not in EXEC.
  - On exec_done:
    - retired_cnt+=1 (wraps mod 2^32); inst_valid<=0.
    - halt_req=1: pc unchanged, halted<=1, -> HALT. Halt has priority over redirect; ebreak counts as retired.
    - else redirect=1 and branch_target[1:0]!=0: pc unchanged, err<=1, halted<=1, -> HALT. The instruction still counts as retired.
    - else redirect=1: pc<=branch_target, -> REQ.
    - else: pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0), -> REQ.
- HALT: absorbing; no further requests; only reset exits.
- Latency, no stalls (ready=1, response one cycle after acceptance, exec_done one cycle after inst_valid rises): 4 cycles per instruction (REQ, WAIT, EXEC, EXEC).

Test Plan:
- Reset release, memory always ready with 1-cycle response, exec_done 1 cycle after inst_valid, 3 instructions -> imem_addr sequence 8000_0000, 8000_0004, 8000_0008; retired_cnt=3; 4 cycles per instruction.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid=1 and imem_addr=8000_0000 stable for all 5 cycles; exactly one request accepted.
- exec_done with redirect=1, branch_target=8000_0100 -> next imem_addr=8000_0100; with branch_target=8000_0102 -> err=1, halted=1, pc unchanged, retired_cnt incremented.
- exec_done with halt_req=1 and redirect=1 together -> halted=1, err=0, pc unchanged, no further imem_req_valid.
- Response withheld, TIMEOUT=16 -> err=1, halted=1 after 16 cycles in WAIT; a late imem_rsp_valid is ignored and inst_valid stays 0.
- rst asserted low during WAIT -> outputs reset immediately (asynchronously); after release, fetch restarts at 8000_0000 with retired_cnt=0.
- pc=FFFF_FFFC, sequential exec_done -> pc wraps to 0000_0000.
